// File: rtl/id_stage.sv
// Instruction decode stage: register file with write-back bypass, opcode decode, load-use hazard detection.
// Latency: 0 cycles (combinational decode); register file and stall counter update on the rising clock.
// Backpressure: asserts stall for one cycle on a load-use hazard and emits a control bubble on stall or flush.
//
// Ports:
//   clock, rst_n                      - stage clock (rising edge), asynchronous active-low reset
//   instr_id, pc_id                   - instruction and its PC from the IF/ID buffer
//   wb_regWrt, wb_rd, wb_data         - register file write-back port (bypassed to same-cycle reads)
//   memRead_ex, rd_ex                 - load flag and destination of the instruction currently in EX
//   flush                             - taken branch/jump resolved in EX; forces a bubble
//   aluOp_id ... jumpMem_id           - decoded control bundle (all zero during a bubble)
//   rd_id, pc_plus_y_id, xrs_id,
//   xrt_id, y_id                      - destination index and datapath operands
//   stall, stall_count                - hold request to fetch and saturating count of stall cycles
module id_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int REG_COUNT = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [31:0]       instr_id,
    input  logic [31:0]       pc_id,
    input  logic              wb_regWrt,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              memRead_ex,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic              flush,
    output logic [2:0]        aluOp_id,
    output logic              memRead_id,
    output logic              memWrite_id,
    output logic              aluSrc_id,
    output logic [1:0]        writeBackControl_id,
    output logic              regWrt_id,
    output logic              branchZero_id,
    output logic              branchNeg_id,
    output logic              jump_id,
    output logic              jumpMem_id,
    output logic [ADDR_W-1:0] rd_id,
    output logic [31:0]       pc_plus_y_id,
    output logic [DATA_W-1:0] xrs_id,
    output logic [DATA_W-1:0] xrt_id,
    output logic [31:0]       y_id,
    output logic              stall,
    output logic [31:0]       stall_count
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_NEG   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;

    localparam logic [1:0] WBC_ALU = 2'b00;
    localparam logic [1:0] WBC_MEM = 2'b01;
    localparam logic [1:0] WBC_PCY = 2'b10;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] wbc;
        logic       reg_wrt;
        logic       branch_zero;
        logic       branch_neg;
        logic       jump;
        logic       jump_mem;
    } ctrl_t;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    ctrl_t             dec;
    ctrl_t             ctrl;
    logic              uses_rs;
    logic              uses_rt;
    logic              bubble;

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [31:0]       stall_count_q;
    logic [31:0]       stall_count_d;

    assign opcode = instr_id[31:28];
    assign rd_id  = instr_id[27:22];
    assign rs     = instr_id[21:16];
    assign rt     = instr_id[15:10];

    // Opcode decode; undefined opcodes fall through to the all-zero NOP bundle.
    always_comb begin
        dec     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_SVPC: begin
                dec.reg_wrt = 1'b1;
                dec.wbc     = WBC_PCY;
            end
            OP_LD: begin
                dec.mem_read = 1'b1;
                dec.reg_wrt  = 1'b1;
                dec.wbc      = WBC_MEM;
                dec.alu_op   = ALU_PASSA;
                uses_rs      = 1'b1;
            end
            OP_ST: begin
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_PASSA;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADD: begin
                dec.reg_wrt = 1'b1;
                dec.alu_op  = ALU_ADD;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_INC: begin
                dec.reg_wrt = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_ADD;
                uses_rs     = 1'b1;
            end
            OP_NEG: begin
                dec.reg_wrt = 1'b1;
                dec.alu_op  = ALU_NEG;
                uses_rs     = 1'b1;
            end
            OP_SUB: begin
                dec.reg_wrt = 1'b1;
                dec.alu_op  = ALU_SUB;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_J: begin
                dec.jump   = 1'b1;
                dec.alu_op = ALU_PASSA;
                uses_rs    = 1'b1;
            end
            OP_BRZ: begin
                dec.branch_zero = 1'b1;
                dec.alu_op      = ALU_PASSA;
                uses_rs         = 1'b1;
            end
            OP_JM: begin
                dec.jump_mem = 1'b1;
                dec.mem_read = 1'b1;
                dec.alu_op   = ALU_PASSA;
                uses_rs      = 1'b1;
            end
            OP_BRN: begin
                dec.branch_neg = 1'b1;
                dec.alu_op     = ALU_PASSA;
                uses_rs        = 1'b1;
            end
            default: begin
                dec = '0;
            end
        endcase
    end

    // memRead_ex covers JM in EX as well, since JM also reads memory.
    // Flush wins: the dependent instruction is being discarded anyway.
    assign stall  = memRead_ex & (((rd_ex == rs) & uses_rs) | ((rd_ex == rt) & uses_rt)) & ~flush;
    assign bubble = stall | flush;
    assign ctrl   = bubble ? '0 : dec;

    assign aluOp_id            = ctrl.alu_op;
    assign memRead_id          = ctrl.mem_read;
    assign memWrite_id         = ctrl.mem_write;
    assign aluSrc_id           = ctrl.alu_src;
    assign writeBackControl_id = ctrl.wbc;
    assign regWrt_id           = ctrl.reg_wrt;
    assign branchZero_id       = ctrl.branch_zero;
    assign branchNeg_id        = ctrl.branch_neg;
    assign jump_id             = ctrl.jump;
    assign jumpMem_id          = ctrl.jump_mem;

    assign y_id         = {{16{instr_id[15]}}, instr_id[15:0]};
    assign pc_plus_y_id = pc_id + y_id;

    // Write-back data is forwarded so the reader sees the value being written this cycle.
    assign xrs_id = (wb_regWrt && (wb_rd == rs)) ? wb_data : regs_q[rs];
    assign xrt_id = (wb_regWrt && (wb_rd == rt)) ? wb_data : regs_q[rt];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_regWrt) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Reference model: architectural register array, opcode control table and the hazard rule.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr_id = '0;
    logic [31:0] pc_id = '0;
    logic        wb_regWrt = 1'b0;
    logic [5:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        memRead_ex = 1'b0;
    logic [5:0]  rd_ex = '0;
    logic        flush = 1'b0;

    logic [2:0]  aluOp_id;
    logic        memRead_id, memWrite_id, aluSrc_id;
    logic [1:0]  writeBackControl_id;
    logic        regWrt_id, branchZero_id, branchNeg_id, jump_id, jumpMem_id;
    logic [5:0]  rd_id;
    logic [31:0] pc_plus_y_id, xrs_id, xrt_id, y_id;
    logic        stall;
    logic [31:0] stall_count;

    always #5 clock = ~clock;

    id_stage dut (
        .clock(clock), .rst_n(rst_n), .instr_id(instr_id), .pc_id(pc_id),
        .wb_regWrt(wb_regWrt), .wb_rd(wb_rd), .wb_data(wb_data),
        .memRead_ex(memRead_ex), .rd_ex(rd_ex), .flush(flush),
        .aluOp_id(aluOp_id), .memRead_id(memRead_id), .memWrite_id(memWrite_id),
        .aluSrc_id(aluSrc_id), .writeBackControl_id(writeBackControl_id),
        .regWrt_id(regWrt_id), .branchZero_id(branchZero_id), .branchNeg_id(branchNeg_id),
        .jump_id(jump_id), .jumpMem_id(jumpMem_id), .rd_id(rd_id),
        .pc_plus_y_id(pc_plus_y_id), .xrs_id(xrs_id), .xrt_id(xrt_id), .y_id(y_id),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [11:0] ctrl;
        logic [5:0]  rd;
        logic [31:0] ppy;
        logic [31:0] xrs;
        logic [31:0] xrt;
        logic [31:0] y;
        logic        stall;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    logic [31:0] m_regs [64];
    logic [31:0] m_cnt;
    logic        p_wr;
    logic [5:0]  p_rd;
    logic [31:0] p_data;
    logic        p_stall;

    // Control bundle order: aluOp, memRead, memWrite, aluSrc, wbc, regWrt, brZ, brN, jump, jumpMem
    function automatic logic [11:0] mk(input logic [2:0] alu, input logic mr, input logic mw,
                                       input logic as, input logic [1:0] wbc, input logic rw,
                                       input logic bz, input logic bn, input logic j, input logic jm);
        return {alu, mr, mw, as, wbc, rw, bz, bn, j, jm};
    endfunction

    function automatic logic [11:0] ctrl_of(input logic [3:0] op);
        case (op)
            4'b1111: return mk(3'b000, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0); // SVPC
            4'b1110: return mk(3'b011, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0); // LD
            4'b0011: return mk(3'b011, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0); // ST
            4'b0100: return mk(3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0); // ADD
            4'b0101: return mk(3'b000, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0); // INC
            4'b0110: return mk(3'b010, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0); // NEG
            4'b0111: return mk(3'b001, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0); // SUB
            4'b1000: return mk(3'b011, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0); // J
            4'b1001: return mk(3'b011, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0); // BRZ
            4'b1010: return mk(3'b011, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1); // JM
            4'b1011: return mk(3'b011, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0); // BRN
            default: return 12'd0;                                      // NOP and undefined
        endcase
    endfunction

    function automatic logic [31:0] mkins(input logic [3:0] op, input logic [5:0] rd,
                                          input logic [5:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One decode cycle: retire the model's effects of the edge just taken, then drive and predict.
    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic wr, input logic [5:0] wrd, input logic [31:0] wd,
                        input logic mre, input logic [5:0] rde, input logic fl);
        exp_t       e;
        logic [3:0] op;
        logic [5:0] rs, rt;
        logic       urs, urt, hz;
        @(posedge clock);
        if (rst_n) begin
            if (p_wr) m_regs[p_rd] = p_data;
            if (p_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
        rst_n = r; instr_id = ins; pc_id = pc; wb_regWrt = wr; wb_rd = wrd; wb_data = wd;
        memRead_ex = mre; rd_ex = rde; flush = fl;
        if (!r) begin
            for (int i = 0; i < 64; i++) m_regs[i] = '0;
            m_cnt = '0;
        end
        op  = ins[31:28];
        rs  = ins[21:16];
        rt  = ins[15:10];
        urs = op inside {4'b1110, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                         4'b1000, 4'b1001, 4'b1010, 4'b1011};
        urt = op inside {4'b0011, 4'b0100, 4'b0111};
        hz  = mre && ((rde == rs && urs) || (rde == rt && urt)) && !fl;
        e.stall = hz;
        e.ctrl  = (hz || fl) ? 12'd0 : ctrl_of(op);
        e.rd    = ins[27:22];
        e.y     = {{16{ins[15]}}, ins[15:0]};
        e.ppy   = pc + e.y;
        e.xrs   = (wr && wrd == rs) ? wd : m_regs[rs];
        e.xrt   = (wr && wrd == rt) ? wd : m_regs[rt];
        e.cnt   = m_cnt;
        q.push_back(e);
        p_wr = wr; p_rd = wrd; p_data = wd; p_stall = hz;
    endtask

    // Monitor: the stage always presents a result, so compare one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl", {20'd0, aluOp_id, memRead_id, memWrite_id, aluSrc_id, writeBackControl_id,
                             regWrt_id, branchZero_id, branchNeg_id, jump_id, jumpMem_id}, {20'd0, e.ctrl});
                chk("rd_id", {26'd0, rd_id}, {26'd0, e.rd});
                chk("pc_plus_y", pc_plus_y_id, e.ppy);
                chk("xrs", xrs_id, e.xrs);
                chk("xrt", xrt_id, e.xrt);
                chk("y_id", y_id, e.y);
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                chk("stall_count", stall_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) m_regs[i] = '0;
        m_cnt = '0; p_wr = 1'b0; p_rd = '0; p_data = '0; p_stall = 1'b0;
        #2 rst_n = 1'b0;

        // Held in reset, then release while writing r5.
        step(0, 32'd0, 32'd0, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        step(0, 32'd0, 32'd0, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        step(1, 32'd0, 32'd0, 1, 6'd5, 32'h0000_00AA, 0, 6'd0, 0);
        // ADD rd=1 rs=5 rt=5 reads the written value.
        step(1, mkins(4'b0100, 6'd1, 6'd5, {6'd5, 10'd0}), 32'h40, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        // Same-cycle bypass into INC rs=7 with negative immediate.
        step(1, mkins(4'b0101, 6'd2, 6'd7, 16'hFFFF), 32'h44, 1, 6'd7, 32'h1234, 0, 6'd0, 0);
        // Load-use on rt, then the load has moved on.
        step(1, mkins(4'b0111, 6'd4, 6'd2, {6'd3, 10'd0}), 32'h48, 0, 6'd0, 32'd0, 1, 6'd3, 0);
        step(1, mkins(4'b0111, 6'd4, 6'd2, {6'd3, 10'd0}), 32'h48, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        // INC does not read rt, so a matching rt field is not a hazard.
        step(1, mkins(4'b0101, 6'd4, 6'd4, {6'd3, 10'h001}), 32'h4C, 0, 6'd0, 32'd0, 1, 6'd3, 0);
        // Flush overrides the hazard; stall count must not move.
        step(1, mkins(4'b0111, 6'd4, 6'd2, {6'd3, 10'd0}), 32'h50, 0, 6'd0, 32'd0, 1, 6'd3, 1);
        // Stall together with a write-back: the write still lands.
        step(1, mkins(4'b1110, 6'd8, 6'd3, 16'd0), 32'h54, 1, 6'd9, 32'hDEAD_BEEF, 1, 6'd3, 0);
        // SVPC with negative offset wraps modulo 2^32.
        step(1, mkins(4'b1111, 6'd10, 6'd0, 16'h8000), 32'h100, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        // Read back r9, then reset mid-cycle while reading r9 and r5.
        step(1, mkins(4'b0100, 6'd1, 6'd9, {6'd5, 10'd0}), 32'h104, 0, 6'd0, 32'd0, 0, 6'd0, 0);
        step(0, mkins(4'b0100, 6'd1, 6'd9, {6'd5, 10'd0}), 32'h108, 1, 6'd20, 32'h5555_0000, 0, 6'd0, 0);
        step(1, mkins(4'b0100, 6'd1, 6'd9, {6'd5, 10'd0}), 32'h10C, 0, 6'd0, 32'd0, 0, 6'd0, 0);

        // Randomised traffic over a small register window to make hazards and bypasses common.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) != 0,
                 mkins(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                       {6'($urandom_range(0, 7)), 10'($urandom)}),
                 $urandom, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), $urandom_range(0, 4) == 0);
        end

        repeat (2) @(negedge clock);
        chk("queue_drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage that directly feeds id_ex_buf. It holds the 64-entry architectural register file with write-back bypass, and decodes the 4-bit opcode into the control bundle id_ex_buf latches. It also computes pc_plus_y and detects load-use hazards, stalling fetch for one cycle and inserting a bubble. It honours an EX-stage flush (taken branch/jump) by emitting a bubble.

Parameters:
DATA_W, 32, register/datapath width
ADDR_W, 6, register index width
REG_COUNT, 64, number of registers (2**ADDR_W)

Ports:
clock  in  1  stage clock, rising-edge
rst_n  in  1  asynchronous active-low reset
instr_id  in  32  instruction from IF/ID buffer; opcode[31:28], rd[27:22], rs[21:16], rt[15:10], y = sext(instr[15:0])
pc_id  in  32  PC of instr_id
wb_regWrt  in  1  write-back enable
wb_rd  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back data
memRead_ex, rd_ex  in  1, ADDR_W  load flag and destination of instruction now in EX
flush  in  1  taken branch/jump resolved in EX
aluOp_id  out  3  000 add, 001 sub, 010 neg A, 011 pass A, 100 pass B
memRead_id, memWrite_id, aluSrc_id  out  1 each  aluSrc 1 = y as B operand
writeBackControl_id  out  2  00 ALU, 01 memory, 10 pc_plus_y
regWrt_id, branchZero_id, branchNeg_id, jump_id, jumpMem_id  out  1 each  control flags
rd_id  out  ADDR_W  destination index
pc_plus_y_id, xrs_id, xrt_id, y_id  out  32 each  datapath operands
stall  out  1  hold PC and IF/ID buffer this cycle
stall_count  out  32  saturating count of stall cycles

Behaviour:
- Decode (combinational from instr_id):
  - 0000 NOP: all zero.
  - 1111 SVPC: regWrt, wbc=10.
  - 1110 LD: memRead, regWrt, wbc=01, aluOp=011.
  - 0011 ST: memWrite, aluOp=011.
  - 0100 ADD: regWrt, aluOp=000.
  - 0101 INC: regWrt, aluSrc, aluOp=000.
  - 0110 NEG: regWrt, aluOp=010.
  - 0111 SUB: regWrt, aluOp=001.
  - 1000 J: jump, aluOp=011.
  - 1001 BRZ: branchZero, aluOp=011.
  - 1010 JM: jumpMem, memRead, aluOp=011.
  - 1011 BRN: branchNeg, aluOp=011.
  - Undefined opcodes (0001, 0010, 1100, 1101) decode as NOP.
- Operand use:
  - rs is read by LD, ST, ADD, INC, NEG, SUB, J, BRZ, JM, BRN.
  - rt is read by ST, ADD, SUB.
- Arithmetic: y_id = {{16{instr[15]}}, instr[15:0]}; pc_plus_y_id = pc_id + y_id, mod 2^32, no overflow flag.
- Register file:
  - 64x32, all registers writable, including r0.
  - Written on rising clock when wb_regWrt=1.
  - Reads are combinational.
  - Bypass: if wb_regWrt and wb_rd equals rs (or rt), xrs_id (or xrt_id) = wb_data in the same cycle.
- Hazard: stall = memRead_ex & (rd_ex==rs & uses_rs | rd_ex==rt & uses_rt) & ~flush.
  - A JM in EX counts as a load.
  - Stall lasts exactly one cycle, because the load advances out of EX.
- Bubble: when stall or flush = 1, all control outputs are 0. Datapath outputs still reflect instr_id (don't-care downstream).
- Priority: flush > stall > normal decode. Simultaneous wb write and stall: the write still occurs.
- stall_count: +1 on each rising clock with stall=1; saturates at 0xFFFFFFFF; no wrap.
- Reset (rst_n=0, asynchronous, anytime including mid-stall):
  - All 64 registers = 0 and stall_count = 0 immediately.
  - Combinational outputs follow the cleared registers: xrs_id/xrt_id = 0 unless bypassed.
  - A write presented on the edge where rst_n rises is ignored.
- Only sequential state: the register file and stall_count. Decode latency is 0 cycles; id_ex_buf provides the pipeline register.

Test Plan:
- Reset, then write r5=0x0000_00AA via WB; next decode ADD rd=1, rs=5, rt=5 -> xrs_id=xrt_id=0xAA, regWrt_id=1, aluOp_id=000, stall=0.
- Same-cycle bypass: wb_regWrt=1, wb_rd=7, wb_data=0x1234 while decoding INC rs=7, y=0xFFFF -> xrs_id=0x1234, y_id=0xFFFF_FFFF, aluSrc_id=1.
- Load-use: memRead_ex=1, rd_ex=3, SUB rs=2, rt=3 -> stall=1 and all controls 0 for one cycle. Next cycle memRead_ex=0 -> normal SUB decode; stall_count=1.
- Load, non-dependent: memRead_ex=1, rd_ex=3, INC rs=4 with instr[15:10]=3 -> stall=0, because INC does not use rt.
- Flush and hazard together: flush=1 plus load-use condition -> stall=0, all controls 0; stall_count unchanged.
- SVPC pc_id=0x100, y=0x8000 -> pc_plus_y_id=0xFFFF_8100, wbc=10. Assert rst_n=0 mid-cycle -> register reads return 0 immediately and stall_count=0.
